dlfloat_dot_engine: RTL and testbench
=====================================

Name: dlfloat_dot_engine

Overview:
Parametrised successor to the free-running DLFloat MAC. Accepts operand pairs over a valid/ready stream and computes a dot product of programmable length N. The sum goes in one accumulator with a registered multiply stage and a registered accumulate stage. The result leaves as a handshaken byte stream, LSB byte first. It sits between the pad-level byte/word wrappers and the top-level IO.

Parameters:
EXP_W, 6, exponent field width
MAN_W, 9, stored mantissa width (hidden 1 implied)
BIAS, 31, exponent bias; must equal 2^(EXP_W-1)-1
LEN_W, 8, width of vector-length field; N ranges 1..2^LEN_W-1
W (derived), 1+EXP_W+MAN_W = 16, word width
NB (derived), ceil(W/8) = 2, output bytes per result

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches len and clears accumulator; honoured in IDLE only
len  in  LEN_W  number of operand pairs; 0 is treated as 1
in_valid  in  1  in_data holds an operand
in_ready  out  1  engine accepts in_data this cycle
in_data  in  W  operand word; A first, then B, alternating
out_valid  out  1  out_byte holds a result byte
out_ready  in  1  consumer takes out_byte
out_byte  out  8  result byte, LSB first, upper bits of last byte zero-padded
busy  out  1  high in every state except IDLE
ovf  out  1  sticky; set when the accumulator saturates; cleared by start

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_byte=0, busy=0, ovf=0. FSM goes to IDLE; accumulator, product register and counters are 0.
- Format: {sign, exp[EXP_W], man[MAN_W]}. 0x0000 is zero. All-ones (0xFFFF) is the saturate/NaN code. No subnormals. Mantissa truncates toward zero.
- Multiply:
  - If either operand is 0, product = 0.
  - If either operand is all-ones, product = all-ones.
  - If ea+eb <= BIAS, flush to 0.
  - If ea+eb >= BIAS+2^EXP_W-1, product = all-ones.
  - Otherwise e = ea+eb-BIAS, plus 1 if the top bit of the mantissa product is set; mantissa is the top MAN_W bits after the hidden 1; sign = sa^sb.
- Add:
  - Align the smaller exponent by right shift; add or subtract the mantissas; renormalise with a leading-one search.
  - Exact cancellation gives 0x0000.
  - Exponent < 1 after renormalisation flushes to 0.
  - Exponent overflow gives all-ones and sets ovf.
  - An all-ones input gives an all-ones output.
  - Sign is that of the larger magnitude; a tie gives sign 0.
- FSM states: IDLE, LOAD_A, LOAD_B, MUL, ACC, DRAIN.
  - IDLE: in_ready=0. On start: cnt<=0, acc<=0, ovf<=0, N<=max(len,1), go to LOAD_A.
  - LOAD_A: in_ready=1. On in_valid, latch A and go to LOAD_B.
  - LOAD_B: in_ready=1. On in_valid, latch B and go to MUL.
  - MUL: the product register loads mul(A,B) on this edge; go to ACC.
  - ACC: acc<=add(acc, prod); cnt<=cnt+1. If cnt+1==N, load the shift register with acc's next value, set byte_idx=0 and go to DRAIN; otherwise go to LOAD_A.
  - DRAIN: out_valid=1 and out_byte = byte byte_idx. Each out_ready cycle advances byte_idx. After byte NB-1 is accepted, go to IDLE with out_valid=0 on the next cycle.
- Throughput: 4 cycles per pair with zero stall. Latency from the last B accepted to the first out_valid is 2 cycles.
- out_byte is held stable while out_valid=1 and out_ready=0.
- start outside IDLE is ignored. in_valid in IDLE or DRAIN is not accepted.
- Reset mid-operation aborts immediately to reset values; any partial result is discarded.
- cnt is LEN_W bits wide; N = 2^LEN_W-1 completes without wrap.

Decomposition:
- Package dlfloat_pkg holds: EXP_W, MAN_W, BIAS, W, the ZERO and SAT codes, the state enum, and field-extract functions for sign, exp and man.
- One combinational sub-module, dlfloat_arith_core, with ports mul(a,b) and add(x,y). It is instantiated once; the FSM sequences it.

Test Plan:
1. len=1, A=0x3E00 (1.0), B=0x4000 (2.0) -> bytes 0x00, 0x40; ovf=0; first out_valid 2 cycles after B is accepted.
2. len=2, pairs (0x3E00,0x4000) then (0x3F00,0x4000) -> 2.0 + 3.0 = 5.0 -> bytes 0x80, 0x42.
3. len=2, pairs (0x3E00,0x4000) then (0xBE00,0x4000) -> exact cancel -> 0x00, 0x00.
4. len=2, pair (0x7E00,0x7E00) then (0x3E00,0x3E00) -> result 0xFFFF (bytes 0xFF, 0xFF); ovf=1 and stays 1 until the next start.
5. Backpressure: hold out_ready=0 for 5 cycles in DRAIN -> out_byte stable at 0x00, then 0x40 follows only after the first byte is accepted. Toggle in_valid randomly -> same result as scenario 2.
6. Assert rst_n low in LOAD_B during scenario 2 -> all outputs return to reset values asynchronously. A fresh start with len=0 and pair (0x0000, 0x4000) -> bytes 0x00, 0x00.

Source files
------------

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat format constants, FSM state codes and field helpers for the dot-product engine.
package dlfloat_pkg;

  localparam int unsigned EXP_W = 6;
  localparam int unsigned MAN_W = 9;
  localparam int unsigned BIAS  = 31;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned NB    = (W + 7) / 8;

  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] SAT  = '1;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_A = 3'd1;
  localparam state_t ST_LOAD_B = 3'd2;
  localparam state_t ST_MUL    = 3'd3;
  localparam state_t ST_ACC    = 3'd4;
  localparam state_t ST_DRAIN  = 3'd5;

  function automatic logic f_sign(input logic [W-1:0] x);
    return x[W-1];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [W-1:0] x);
    return x[W-2 -: EXP_W];
  endfunction

  function automatic logic [MAN_W-1:0] f_man(input logic [W-1:0] x);
    return x[MAN_W-1:0];
  endfunction

endpackage

// File: rtl/dlfloat_dot_engine_if.sv
// Operand stream, control and result byte stream of the DLFloat dot-product engine.
interface dlfloat_dot_engine_if;
  import dlfloat_pkg::*;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_byte;
  logic             busy;
  logic             ovf;

  modport master (output start, len, in_valid, in_data, out_ready,
                  input  in_ready, out_valid, out_byte, busy, ovf);
  modport slave  (input  start, len, in_valid, in_data, out_ready,
                  output in_ready, out_valid, out_byte, busy, ovf);
endinterface

// File: rtl/dlfloat_arith_core.sv
// Combinational DLFloat multiplier and adder; the engine FSM sequences both through registers.
module dlfloat_arith_core
  import dlfloat_pkg::*;
(
  input  logic [W-1:0] mul_a,
  input  logic [W-1:0] mul_b,
  output logic [W-1:0] mul_p,
  input  logic [W-1:0] add_x,
  input  logic [W-1:0] add_y,
  output logic [W-1:0] add_s
);

  localparam int unsigned EW2 = EXP_W + 2;
  localparam int unsigned MW  = MAN_W + 1;
  localparam int unsigned PW2 = 2 * MW;
  localparam int unsigned PW  = $clog2(MW + 1);

  logic [EW2-1:0] esum;
  logic [PW2-1:0] mprod;

  // Multiply: exponent sum with range guards, mantissa product truncated
  always_comb begin
    esum  = EW2'(f_exp(mul_a)) + EW2'(f_exp(mul_b));
    mprod = PW2'({1'b1, f_man(mul_a)}) * PW2'({1'b1, f_man(mul_b)});
    mul_p = {f_sign(mul_a) ^ f_sign(mul_b),
             EXP_W'(esum - EW2'(BIAS) + EW2'(mprod[PW2-1])),
             MAN_W'(mprod >> (mprod[PW2-1] ? MAN_W + 1 : MAN_W))};
    if (mul_a == ZERO || mul_b == ZERO)                 mul_p = ZERO;
    else if (mul_a == SAT || mul_b == SAT)              mul_p = SAT;
    else if (esum <= EW2'(BIAS))                        mul_p = ZERO;
    else if (esum >= EW2'(BIAS + 2**EXP_W - 1))         mul_p = SAT;
  end

  logic           x_big;
  logic [W-1:0]   big;
  logic [W-1:0]   sml;
  logic [EXP_W-1:0] dexp;
  logic [MW-1:0]  m_sml_sh;
  logic [MW:0]    msum;
  logic [MW:0]    norm;
  logic [PW-1:0]  pos;
  logic [EW2-1:0] eb;

  // Add: align smaller operand, add/subtract, renormalise on the leading one.
  // eb carries the result exponent offset by MAN_W so it never goes negative.
  always_comb begin
    x_big    = add_x[W-2:0] >= add_y[W-2:0];
    big      = x_big ? add_x : add_y;
    sml      = x_big ? add_y : add_x;
    dexp     = f_exp(big) - f_exp(sml);
    m_sml_sh = {1'b1, f_man(sml)} >> dexp;
    if (f_sign(big) ^ f_sign(sml)) msum = {2'b01, f_man(big)} - {1'b0, m_sml_sh};
    else                           msum = {2'b01, f_man(big)} + {1'b0, m_sml_sh};
    pos = '0;
    for (int unsigned i = 0; i <= MW; i++) begin
      if (msum[i]) pos = PW'(i);
    end
    norm  = msum << (PW'(MW) - pos);
    eb    = EW2'(f_exp(big)) + EW2'(pos);
    add_s = {f_sign(big), EXP_W'(eb - EW2'(MAN_W)), MAN_W'(norm >> 1)};
    if (add_x == SAT || add_y == SAT)                   add_s = SAT;
    else if (add_x == ZERO)                             add_s = add_y;
    else if (add_y == ZERO)                             add_s = add_x;
    else if (msum == '0 || eb <= EW2'(MAN_W))           add_s = ZERO;
    else if (eb > EW2'(MAN_W + 2**EXP_W - 1))           add_s = SAT;
  end

endmodule

// File: rtl/dlfloat_dot_engine.sv
// DLFloat dot-product engine: streamed operand pairs, one accumulator, result drained LSB byte first.
module dlfloat_dot_engine
  import dlfloat_pkg::*;
(
  input logic                 clk,
  input logic                 rst_n,
  dlfloat_dot_engine_if.slave bus
);

  localparam int unsigned SW  = NB * 8;
  localparam int unsigned BIW = (NB > 1) ? $clog2(NB) : 1;

  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d, prod_q, prod_d, acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d, n_q, n_d;
  logic [SW-1:0]    sreg_q, sreg_d;
  logic [BIW-1:0]   bidx_q, bidx_d;
  logic             in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic             busy_q, busy_d, ovf_q, ovf_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic [W-1:0]     mul_p, add_s;

  dlfloat_arith_core u_core (
    .mul_a (a_q),
    .mul_b (b_q),
    .mul_p (mul_p),
    .add_x (acc_q),
    .add_y (prod_q),
    .add_s (add_s)
  );

  // Next-state and next-output logic; all outputs are registered from these
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    n_d        = n_q;
    sreg_d     = sreg_q;
    bidx_d     = bidx_q;
    ovf_d      = ovf_q;
    out_byte_d = out_byte_q;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        cnt_d   = '0;
        acc_d   = ZERO;
        ovf_d   = 1'b0;
        n_d     = (bus.len == '0) ? LEN_W'(1) : bus.len;
        state_d = ST_LOAD_A;
      end
      ST_LOAD_A: if (bus.in_valid) begin
        a_d     = bus.in_data;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: if (bus.in_valid) begin
        b_d     = bus.in_data;
        state_d = ST_MUL;
      end
      ST_MUL: begin
        prod_d  = mul_p;
        state_d = ST_ACC;
      end
      ST_ACC: begin
        acc_d = add_s;
        cnt_d = cnt_q + LEN_W'(1);
        if (add_s == SAT) ovf_d = 1'b1;
        if (cnt_d == n_q) begin
          sreg_d     = SW'(add_s);
          bidx_d     = '0;
          out_byte_d = add_s[7:0];
          state_d    = ST_DRAIN;
        end else begin
          state_d = ST_LOAD_A;
        end
      end
      ST_DRAIN: if (bus.out_ready) begin
        if (bidx_q == BIW'(NB - 1)) begin
          out_byte_d = 8'h00;
          state_d    = ST_IDLE;
        end else begin
          bidx_d     = bidx_q + BIW'(1);
          sreg_d     = sreg_q >> 8;
          out_byte_d = sreg_d[7:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
    out_valid_d = (state_d == ST_DRAIN);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      sreg_q      <= '0;
      bidx_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      sreg_q      <= sreg_d;
      bidx_q      <= bidx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_byte  = out_byte_q;
  assign bus.busy      = busy_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_dlfloat_dot_engine.sv
// Self-checking bench for dlfloat_dot_engine: directed vector table, handshake corner cases, random dot products.
module tb_dlfloat_dot_engine;
  import dlfloat_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dlfloat_dot_engine_if bus ();
  dlfloat_dot_engine dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] va [256];
  logic [15:0] vb [256];

  typedef struct {
    int          len;
    int          np;
    logic [15:0] a0, b0, a1, b1;
    logic [15:0] res;
    logic        ovf;
  } vec_t;
  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Reference arithmetic on real-valued mantissa/exponent integers
  function automatic logic [15:0] mul_ref(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, e, p;
    if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
    if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
    ea = int'(a[14:9]);
    eb = int'(b[14:9]);
    if (ea + eb <= 31) return 16'h0000;
    if (ea + eb >= 94) return 16'hFFFF;
    p = (512 + int'(a[8:0])) * (512 + int'(b[8:0]));
    e = ea + eb - 31;
    if (p >= (1 << 19)) begin
      p = p / 2;
      e++;
    end
    return {a[15] ^ b[15], 6'(e), 9'(p / 512 - 512)};
  endfunction

  function automatic logic [15:0] add_ref(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] l, s;
    int el, es, ml, ms, sum, e;
    if (x == 16'hFFFF || y == 16'hFFFF) return 16'hFFFF;
    if (x == 16'h0000) return y;
    if (y == 16'h0000) return x;
    if (x[14:0] >= y[14:0]) begin l = x; s = y; end
    else begin l = y; s = x; end
    el = int'(l[14:9]);
    es = int'(s[14:9]);
    ml = 512 + int'(l[8:0]);
    ms = 512 + int'(s[8:0]);
    ms = (el - es >= 16) ? 0 : ms / (1 << (el - es));
    sum = (l[15] == s[15]) ? ml + ms : ml - ms;
    if (sum == 0) return 16'h0000;
    e = el;
    while (sum >= 1024) begin sum = sum / 2; e++; end
    while (sum < 512) begin sum = sum * 2; e--; end
    if (e < 1) return 16'h0000;
    if (e > 63) return 16'hFFFF;
    return {l[15], 6'(e), 9'(sum - 512)};
  endfunction

  task automatic dot_ref(input int np, output logic [15:0] r, output logic ov);
    r  = 16'h0000;
    ov = 1'b0;
    for (int p = 0; p < np; p++) begin
      r = add_ref(r, mul_ref(va[p], vb[p]));
      if (r == 16'hFFFF) ov = 1'b1;
    end
  endtask

  function automatic logic [15:0] rand_op();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 29))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return w;
      default: w[14:9] = 6'($urandom_range(24, 38));
    endcase
    return w;
  endfunction

  task automatic send_word(input string tag, input logic [15:0] w, input bit rnd);
    int t = 0;
    if (rnd) begin
      for (int k = 0; k < 6 && $urandom_range(0, 1) == 1; k++) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!bus.in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!bus.in_ready) timeout_fail({tag, "_in_ready"});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int stall, input logic [15:0] exp_r, output logic [15:0] r);
    int t;
    r = 16'h0000;
    for (int i = 0; i < NB; i++) begin
      t = 0;
      while (!bus.out_valid && t < 10) begin @(posedge clk); #1; t++; end
      if (!bus.out_valid) begin
        timeout_fail({tag, "_out_valid"});
        return;
      end
      if (i == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          check({tag, "_hold_byte"}, 32'(bus.out_byte), 32'(exp_r[7:0]));
          check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        end
      end
      r[i*8 +: 8] = bus.out_byte;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
    end
    check({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic run_dot(input string tag, input int lenv, input int np, input bit rnd,
                         input int stall, input logic [15:0] exp_r, input logic exp_ov);
    int lat;
    logic [15:0] r;
    bus.len   = LEN_W'(lenv);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_ovf_clr"}, 32'(bus.ovf), 32'd0);
    for (int p = 0; p < np; p++) begin
      send_word(tag, va[p], rnd);
      send_word(tag, vb[p], rnd);
    end
    lat = 0;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check({tag, "_latency"}, 32'(lat), 32'd2);
    recv(tag, stall, exp_r, r);
    check({tag, "_result"}, 32'(r), 32'(exp_r));
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ov));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_byte"},  32'(bus.out_byte),  32'd0);
    check({tag, "_busy"},      32'(bus.busy),      32'd0);
    check({tag, "_ovf"},       32'(bus.ovf),       32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] er;
    logic        eo;
    int          lenv, np;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    //          len np  a0        b0        a1        b1        result    ovf
    vt[0] = '{1, 1, 16'h3E00, 16'h4000, 16'h0000, 16'h0000, 16'h4000, 1'b0};
    vt[1] = '{2, 2, 16'h3E00, 16'h4000, 16'h3F00, 16'h4000, 16'h4280, 1'b0};
    vt[2] = '{2, 2, 16'h3E00, 16'h4000, 16'hBE00, 16'h4000, 16'h0000, 1'b0};
    vt[3] = '{2, 2, 16'h7E00, 16'h7E00, 16'h3E00, 16'h3E00, 16'hFFFF, 1'b1};
    vt[4] = '{0, 1, 16'h0000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vt[5] = '{1, 1, 16'h3F00, 16'h3F00, 16'h0000, 16'h0000, 16'h4040, 1'b0};
    vt[6] = '{1, 1, 16'hBE00, 16'h4000, 16'h0000, 16'h0000, 16'hC000, 1'b0};
    vt[7] = '{1, 1, 16'h0200, 16'h3C00, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    vt[8] = '{2, 2, 16'h3E00, 16'h3E00, 16'hBD00, 16'h3E00, 16'h3A00, 1'b0};

    #12;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      va[0] = vt[i].a0; vb[0] = vt[i].b0;
      va[1] = vt[i].a1; vb[1] = vt[i].b1;
      run_dot($sformatf("vec%0d", i), vt[i].len, vt[i].np, 1'b0, 0, vt[i].res, vt[i].ovf);
    end

    // Output backpressure on the first byte
    va[0] = 16'h3E00; vb[0] = 16'h4000;
    run_dot("bp", 1, 1, 1'b0, 5, 16'h4000, 1'b0);

    // Irregular in_valid
    va[0] = 16'h3E00; vb[0] = 16'h4000; va[1] = 16'h3F00; vb[1] = 16'h4000;
    run_dot("gaps", 2, 2, 1'b1, 2, 16'h4280, 1'b0);

    // Sticky ovf survives idle cycles, then async reset clears it
    va[0] = 16'h7E00; vb[0] = 16'h7E00; va[1] = 16'h3E00; vb[1] = 16'h3E00;
    run_dot("ovf", 2, 2, 1'b0, 0, 16'hFFFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_sticky", 32'(bus.ovf), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_idle");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while waiting for B aborts the dot product
    bus.len   = LEN_W'(2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    send_word("rst_ab", 16'h3E00, 1'b0);
    check("rst_ab_in_ready", 32'(bus.in_ready), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_ab");
    @(posedge clk); #1;
    rst_n = 1'b1;
    va[0] = 16'h0000; vb[0] = 16'h4000;
    run_dot("rst_fresh", 0, 1, 1'b0, 0, 16'h0000, 1'b0);

    for (int t = 0; t < 30; t++) begin
      lenv = (t % 7 == 3) ? 0 : int'($urandom_range(1, 6));
      np   = (lenv == 0) ? 1 : lenv;
      for (int p = 0; p < np; p++) begin
        va[p] = rand_op();
        vb[p] = rand_op();
      end
      dot_ref(np, er, eo);
      run_dot($sformatf("rnd%0d", t), lenv, np, t[0], (t % 3 == 0) ? int'($urandom_range(1, 4)) : 0, er, eo);
    end

    // Maximum length, counter must not wrap
    for (int p = 0; p < 255; p++) begin
      va[p] = rand_op();
      vb[p] = rand_op();
    end
    dot_ref(255, er, eo);
    run_dot("maxlen", 255, 255, 1'b0, 0, er, eo);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
